// File: rtl/rls_phase_sequencer_pkg.sv
// Shared types for the RLS phase sequencer: phase codes, FSM state codes
// and the state-to-phase decode used for the registered phase output.
package rls_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_GAIN = 2'b01,
        PH_ERR  = 2'b10,
        PH_UPD  = 2'b11
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GAIN    = 3'd1,
        ST_DRAIN_G = 3'd2,
        ST_ERR     = 3'd3,
        ST_UPD     = 3'd4,
        ST_DRAIN_U = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int DRAIN_W = 4;

    // Drains report the phase of the sweep they follow.
    function automatic phase_t phase_of(input state_t st);
        phase_t ph;
        case (st)
            ST_GAIN, ST_DRAIN_G: ph = PH_GAIN;
            ST_ERR:              ph = PH_ERR;
            ST_UPD, ST_DRAIN_U:  ph = PH_UPD;
            default:             ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/rls_phase_sequencer_counter.sv
// Modulo (M+1) index counter with synchronous clear and count enable.
module rls_phase_sequencer_counter #(
    parameter int nBits = 3,
    parameter int M     = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             count,
    output logic [nBits-1:0] r
);

    localparam logic [nBits-1:0] LAST = nBits'(M);

    // Index register: clear wins over count, wraps from M back to 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (count) begin
            r <= (r == LAST) ? '0 : r + nBits'(1);
        end else begin
            r <= r;
        end
    end

endmodule

// File: rtl/rls_phase_sequencer.sv
// Sequences one RLS iteration: GAIN sweep, pipeline drain, ERROR cycle,
// UPDATE sweep, drain, then a one-cycle done pulse.
module rls_phase_sequencer
    import rls_phase_sequencer_pkg::*;
#(
    parameter int nBits = 3,
    parameter int M     = 7,
    parameter int LAT   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic [nBits-1:0] idx,
    output logic [1:0]       phase,
    output logic             idx_valid,
    output logic             done
);

    localparam logic [nBits-1:0]   M_IDX    = nBits'(M);
    localparam logic [DRAIN_W-1:0] LAT_LAST = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic               busy_r;
    logic               done_r;
    phase_t             phase_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic               cnt_clear_s;
    logic               cnt_count_s;
    logic               idx_valid_s;
    logic               in_drain_s;
    logic               drain_last_s;
    logic [nBits-1:0]   idx_r;

    rls_phase_sequencer_counter #(
        .nBits (nBits),
        .M     (M)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear_s),
        .count (cnt_count_s),
        .r     (idx_r)
    );

    assign in_drain_s   = (state_r == ST_DRAIN_G) || (state_r == ST_DRAIN_U);
    assign drain_last_s = (drain_cnt_r == LAT_LAST);

    // Next-state, counter control and datapath strobe decode.
    always_comb begin
        next_state_s = state_r;
        cnt_clear_s  = 1'b0;
        cnt_count_s  = 1'b0;
        idx_valid_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clear_s = 1'b1;
                if (start) begin
                    next_state_s = ST_GAIN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GAIN: begin
                idx_valid_s = ~stall;
                cnt_count_s = ~stall;
                if (!stall && (idx_r == M_IDX)) begin
                    next_state_s = (LAT == 0) ? ST_ERR : ST_DRAIN_G;
                end else begin
                    next_state_s = ST_GAIN;
                end
            end
            ST_DRAIN_G: begin
                if (drain_last_s) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_DRAIN_G;
                end
            end
            ST_ERR: begin
                idx_valid_s  = 1'b1;
                next_state_s = ST_UPD;
            end
            ST_UPD: begin
                idx_valid_s = ~stall;
                cnt_count_s = ~stall;
                if (!stall && (idx_r == M_IDX)) begin
                    next_state_s = (LAT == 0) ? ST_DONE : ST_DRAIN_U;
                end else begin
                    next_state_s = ST_UPD;
                end
            end
            ST_DRAIN_U: begin
                if (drain_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN_U;
                end
            end
            ST_DONE: begin
                cnt_clear_s  = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                cnt_clear_s  = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all computed from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            phase_r <= PH_IDLE;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
            done_r  <= (next_state_s == ST_DONE);
            phase_r <= phase_of(next_state_s);
        end
    end

    // Drain length counter: runs only while in a drain state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_cnt_r <= 4'd0;
        end else if (in_drain_s && !drain_last_s) begin
            drain_cnt_r <= drain_cnt_r + 4'd1;
        end else begin
            drain_cnt_r <= 4'd0;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign phase     = phase_r;
    assign idx       = idx_r;
    assign idx_valid = idx_valid_s;

endmodule
